// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared state, descriptor type and frame-size helper for the serializer
package sti_pkg;

    // Upper bounds for the descriptor fields; configured widths must not exceed these.
    localparam int STI_MAX_PI_W  = 64;
    localparam int STI_MAX_LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } sti_state_t;

    // One queued frame request; bits beyond the configured widths stay zero.
    typedef struct packed {
        logic [STI_MAX_PI_W-1:0]  data;
        logic [STI_MAX_LEN_W-1:0] length;
        logic                     fill;
        logic                     msb;
        logic                     low;
        logic                     end_flag;
    } sti_desc_t;

    // Frame size in bits for length code L.
    function automatic int frame_bits(input int len_code);
        return 8 * (len_code + 1);
    endfunction

endpackage

// File: rtl/sti_desc_fifo.sv
// rtl/sti_desc_fifo.sv - first-word-fall-through descriptor queue
module sti_desc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A full queue refuses pushes even when the head is leaving this cycle.
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
            else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sti_serializer.sv
// rtl/sti_serializer.sv - descriptor-driven parallel-to-serial frame transmitter
module sti_serializer
    import sti_pkg::*;
#(
    parameter int PI_W  = 16,
    parameter int LEN_W = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pi_valid,
    output logic             pi_ready,
    input  logic [PI_W-1:0]  pi_data,
    input  logic [LEN_W-1:0] pi_length,
    input  logic             pi_fill,
    input  logic             pi_msb,
    input  logic             pi_low,
    input  logic             pi_end,
    input  logic             so_ready,
    output logic             so_valid,
    output logic             so_data,
    output logic             so_last,
    output logic             done
);
    localparam int FMAX   = 8 << LEN_W;
    localparam int CNT_W  = $clog2(FMAX);
    localparam int DESC_W = PI_W + LEN_W + 4;

    sti_state_t        state_q, state_d;
    logic [FMAX-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              end_q, end_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DESC_W-1:0] fifo_head;
    sti_desc_t         head;
    logic              unused_head;

    int                f_bits;
    logic [FMAX-1:0]   data_ext;
    logic [FMAX-1:0]   frame;
    logic [FMAX-1:0]   frame_rev;
    logic [FMAX-1:0]   frame_load;

    assign pi_ready = !fifo_full;

    sti_desc_fifo #(
        .W     (DESC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pi_valid),
        .push_data ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Unpack the queue head into the shared descriptor layout.
    always_comb begin
        head          = '0;
        head.data     = STI_MAX_PI_W'(fifo_head[DESC_W-1 -: PI_W]);
        head.length   = STI_MAX_LEN_W'(fifo_head[LEN_W+3 -: LEN_W]);
        head.fill     = fifo_head[3];
        head.msb      = fifo_head[2];
        head.low      = fifo_head[1];
        head.end_flag = fifo_head[0];
    end

    // Padding bits of the descriptor are constant zero.
    assign unused_head = ^head;

    // Build the frame in the low F bits; MSB-first frames are bit-reversed so
    // the next bit to send always sits in sr_q[0].
    always_comb begin
        f_bits    = frame_bits(int'(head.length));
        data_ext  = FMAX'(head.data[PI_W-1:0]);
        frame     = '0;
        frame_rev = '0;
        if (f_bits >= PI_W)
            frame = head.fill ? (data_ext << (f_bits - PI_W)) : data_ext;
        else if (head.low)
            frame = data_ext >> (PI_W - f_bits);
        else
            frame = data_ext & ({FMAX{1'b1}} >> (FMAX - f_bits));
        for (int i = 0; i < FMAX; i++)
            frame_rev[i] = frame[FMAX-1-i];
        frame_load = head.msb ? (frame_rev >> (FMAX - f_bits)) : frame;
    end

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        end_d    = end_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                sr_d     = frame_load;
                cnt_d    = CNT_W'(f_bits - 1);
                end_d    = head.end_flag;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (so_ready) begin
                    if (cnt_q == '0)
                        state_d = end_q ? ST_DONE : (fifo_empty ? ST_IDLE : ST_LOAD);
                    else begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; outputs are derived from next-state values so they come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            end_q    <= 1'b0;
            so_valid <= 1'b0;
            so_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            end_q    <= end_d;
            so_valid <= (state_d == ST_SHIFT);
            so_last  <= (state_d == ST_SHIFT) && (cnt_d == '0);
            done     <= (state_d == ST_DONE);
        end
    end

    assign so_data = sr_q[0];

endmodule

// File: tb/tb_sti_serializer.sv
// tb/tb_sti_serializer.sv - scoreboard bench for sti_serializer
module tb_sti_serializer;
    localparam int PI_W  = 16;
    localparam int LEN_W = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pi_valid = 1'b0;
    logic             pi_ready;
    logic [PI_W-1:0]  pi_data = '0;
    logic [LEN_W-1:0] pi_length = '0;
    logic             pi_fill = 1'b0;
    logic             pi_msb = 1'b0;
    logic             pi_low = 1'b0;
    logic             pi_end = 1'b0;
    logic             so_ready = 1'b1;
    logic             so_valid;
    logic             so_data;
    logic             so_last;
    logic             done;

    always #5 clk = ~clk;

    sti_serializer #(.PI_W(PI_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .pi_valid  (pi_valid),
        .pi_ready  (pi_ready),
        .pi_data   (pi_data),
        .pi_length (pi_length),
        .pi_fill   (pi_fill),
        .pi_msb    (pi_msb),
        .pi_low    (pi_low),
        .pi_end    (pi_end),
        .so_ready  (so_ready),
        .so_valid  (so_valid),
        .so_data   (so_data),
        .so_last   (so_last),
        .done      (done)
    );

    typedef struct packed {
        logic d;
        logic last;
        logic endf;
    } exp_bit_t;

    exp_bit_t sb[$];
    int       errors = 0;
    int       checks = 0;
    int       cyc = 0;
    int       accepted = 0;
    int       done_cnt = 0;
    bit       check_gap = 1'b0;
    bit       gap_armed = 1'b0;
    int       last_end_cyc = 0;
    bit       hold_v = 1'b0;
    logic     hold_d, hold_l;
    bit       exp_done = 1'b0;
    exp_bit_t e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame model: builds the frame bit by bit and queues bits in send order.
    task automatic push_exp(input logic [15:0] d, input int l, input bit fill, input bit msb,
                            input bit low, input bit endf);
        int f;
        int idx;
        logic [31:0] fr;
        exp_bit_t x;
        f  = 8 * (l + 1);
        fr = '0;
        for (int k = 0; k < f; k++) begin
            if (f >= PI_W) begin
                if (fill) begin
                    if (k >= f - PI_W) fr[k] = d[k - (f - PI_W)];
                end else if (k < PI_W) begin
                    fr[k] = d[k];
                end
            end else if (low) begin
                fr[k] = d[k + PI_W - f];
            end else begin
                fr[k] = d[k];
            end
        end
        for (int j = 0; j < f; j++) begin
            idx    = msb ? (f - 1 - j) : j;
            x.d    = fr[idx];
            x.last = (j == f - 1);
            x.endf = endf;
            sb.push_back(x);
        end
    endtask

    task automatic push(input logic [15:0] d, input int l, input bit fill, input bit msb,
                        input bit low, input bit endf);
        int n;
        n         = 0;
        pi_valid  = 1'b1;
        pi_data   = d;
        pi_length = LEN_W'(l);
        pi_fill   = fill;
        pi_msb    = msb;
        pi_low    = low;
        pi_end    = endf;
        @(negedge clk);
        while (!pi_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(pi_ready), 32'd1);
        @(posedge clk);
        #1;
        pi_valid = 1'b0;
        push_exp(d, l, fill, msb, low, endf);
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            so_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        so_ready = 1'b1;
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard compare, hold stability, done pulse and inter-frame gap.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            hold_v    = 1'b0;
            exp_done  = 1'b0;
            gap_armed = 1'b0;
        end else begin
            check("done", 32'(done), 32'(exp_done));
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (hold_v) begin
                check("hold_valid", 32'(so_valid), 32'd1);
                check("hold_data", 32'(so_data), 32'(hold_d));
                check("hold_last", 32'(so_last), 32'(hold_l));
            end
            hold_v = 1'b0;
            if (so_valid) begin
                if (gap_armed) begin
                    check("frame_gap", 32'(cyc - last_end_cyc - 1), 32'd1);
                    gap_armed = 1'b0;
                end
                if (so_ready) begin
                    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("so_data", 32'(so_data), 32'(e.d));
                        check("so_last", 32'(so_last), 32'(e.last));
                        accepted++;
                        if (e.last && e.endf) exp_done = 1'b1;
                        if (e.last && check_gap) begin
                            gap_armed    = 1'b1;
                            last_end_cyc = cyc;
                        end
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = so_data;
                    hold_l = so_last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_so_valid", 32'(so_valid), 32'd0);
        check("rst_so_data", 32'(so_data), 32'd0);
        check("rst_so_last", 32'(so_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pi_ready", 32'(pi_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 8-bit MSB-first slice from the top byte
        push(16'hA5C3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain(1'b0);

        // 32-bit frame, data in MSB half, LSB first
        push(16'h8001, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(1'b0);

        // F == PI_W and low-byte slice, LSB first; also a 24-bit zero-pad-high frame
        push(16'h3C5A, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(16'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(16'hE718, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        drain(1'b0);

        // Fill the queue while a long frame shifts
        check_gap = 1'b1;
        push(16'hFFFF, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("shifting_before_fill", 32'(so_valid), 32'd1);
        push(16'h0001, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(16'h00C0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(16'hBEEF, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ready_at_count3", 32'(pi_ready), 32'd1);
        push(16'h7E00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ready_at_count4", 32'(pi_ready), 32'd0);
        push(16'h1357, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(1'b0);
        check_gap = 1'b0;
        gap_armed = 1'b0;

        // Random backpressure on a 16-bit frame
        push(16'hB38E, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain(1'b1);
        push(16'h4C2D, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(1'b1);

        // End-of-stream frame followed by a queued frame
        done_cnt = 0;
        push(16'h00F0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(16'h5A00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain(1'b0);
        check("done_pulses", 32'(done_cnt), 32'd1);

        // Reset during bit 10 of a 24-bit frame with another frame queued
        acc0 = accepted;
        push(16'hC0DE, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        push(16'hFFFF, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        while ((accepted - acc0) < 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_bit10", 32'(accepted - acc0), 32'd10);
        check("valid_at_bit10", 32'(so_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_so_valid", 32'(so_valid), 32'd0);
        check("mid_rst_so_last", 32'(so_last), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pi_ready", 32'(pi_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(so_valid), 32'd0);
        end
        check("post_rst_pi_ready", 32'(pi_ready), 32'd1);

        // Block still works after reset
        @(posedge clk);
        #1;
        push(16'h6996, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
